// File: rtl/vx_pending_select.sv
// Sticky request collector with a registered fixed-priority or round-robin pick,
// offered on a valid/ready handshake and retired from the pending mask on accept.
module vx_pending_select #(
  parameter int N           = 4,
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int LN          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  set_in,
  input  logic [N-1:0]  clr_in,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [LN-1:0] index_out,
  output logic [N-1:0]  onehot_out,
  output logic [N-1:0]  pending_out
);

  logic [N-1:0]  r_pending;
  logic          r_valid;
  logic [LN-1:0] r_index;
  logic [N-1:0]  r_onehot;

  logic          w_fire;
  logic          w_load;
  logic          w_any;
  logic [N-1:0]  w_clr_mask;
  logic [N-1:0]  w_pending_next;
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_upper_mask;
  logic [N-1:0]  w_cand_upper;
  logic [LN-1:0] w_start;
  logic [LN-1:0] w_sel_index;
  logic [N-1:0]  w_sel_onehot;

  function automatic logic [LN-1:0] f_lowest(input logic [N-1:0] mask);
    logic [LN-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = LN'(i);
    end
    return idx;
  endfunction

  assign w_fire = r_valid & ready_in;
  assign w_load = !r_valid || w_fire;

  // Set wins over both cancel and retire, so a re-request during its own grant survives.
  assign w_clr_mask     = clr_in | (w_fire ? r_onehot : '0);
  assign w_pending_next = (r_pending & ~w_clr_mask) | set_in;

  // The bit on offer is excluded even in the accept cycle so it is never granted twice.
  assign w_cand = r_pending & ~clr_in & ~(r_valid ? r_onehot : '0);
  assign w_any  = |w_cand;

  // Round-robin search: prefer candidates at or above the start point, else wrap to the lowest.
  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_upper_mask[i] = (i >= int'(w_start));
    end
  end

  assign w_cand_upper = w_cand & w_upper_mask;
  assign w_sel_index  = (|w_cand_upper) ? f_lowest(w_cand_upper) : f_lowest(w_cand);
  assign w_sel_onehot = w_any ? (N'(1) << w_sel_index) : '0;

  generate
    if (ROUND_ROBIN && (N > 1)) begin : g_rr
      logic [LN-1:0] r_last;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_last <= LN'(N - 1);
        end else if (w_fire) begin
          r_last <= r_index;
        end
      end

      assign w_start = (r_last == LN'(N - 1)) ? '0 : r_last + LN'(1);
    end else begin : g_fixed
      assign w_start = '0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_index   <= '0;
      r_onehot  <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_load) begin
        r_valid  <= w_any;
        r_index  <= w_sel_index;
        r_onehot <= w_sel_onehot;
      end
    end
  end

  assign valid_out   = r_valid;
  assign index_out   = r_index;
  assign onehot_out  = r_onehot;
  assign pending_out = r_pending;

  a_onehot_match: assert property (@(posedge clk) disable iff (reset)
    r_valid |-> (r_onehot == (N'(1) << r_index)));

  a_idle_zero: assert property (@(posedge clk) disable iff (reset)
    !r_valid |-> (r_onehot == '0 && r_index == '0));

  a_index_range: assert property (@(posedge clk) disable iff (reset)
    int'(r_index) < N);

  a_hold_offer: assert property (@(posedge clk) disable iff (reset)
    (r_valid && !ready_in) |=> (r_valid && $stable(r_index) && $stable(r_onehot)));

endmodule

// File: tb/tb_vx_pending_select.sv
// Randomized and directed bench for vx_pending_select: a fixed-priority and a round-robin
// instance share stimulus, each scored against a rule-level model through an expectation queue.
module tb_vx_pending_select;

  localparam int N  = 4;
  localparam int LN = 2;

  typedef struct {
    logic         valid;
    int           idx;
    logic [N-1:0] onehot;
    logic [N-1:0] pend;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  set_in;
  logic [N-1:0]  clr_in;
  logic          ready_in;

  logic          fx_valid, rr_valid;
  logic [LN-1:0] fx_index, rr_index;
  logic [N-1:0]  fx_onehot, rr_onehot;
  logic [N-1:0]  fx_pend, rr_pend;

  int errors = 0;
  int checks = 0;

  // Reference state per unit: 0 = fixed priority, 1 = round robin.
  logic [N-1:0] m_pend  [2];
  logic         m_valid [2];
  int           m_idx   [2];
  int           m_last  [2];

  exp_t q_fx[$];
  exp_t q_rr[$];

  always #5 clk = ~clk;

  vx_pending_select #(.N(N), .ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
    .valid_out(fx_valid), .ready_in(ready_in), .index_out(fx_index),
    .onehot_out(fx_onehot), .pending_out(fx_pend)
  );

  vx_pending_select #(.N(N), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
    .valid_out(rr_valid), .ready_in(ready_in), .index_out(rr_index),
    .onehot_out(rr_onehot), .pending_out(rr_pend)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u]  = '0;
      m_valid[u] = 1'b0;
      m_idx[u]   = 0;
      m_last[u]  = N - 1;
    end
  endtask

  // Advances one unit by one clock, straight from the pending/candidate/handshake rules.
  task automatic model_step(input int u, input logic [N-1:0] s, input logic [N-1:0] c,
                            input logic r);
    logic         fire;
    logic [N-1:0] np;
    int           start;
    int           pick;
    bit           found;
    fire = m_valid[u] && r;
    for (int i = 0; i < N; i++) begin
      np[i] = s[i] || (m_pend[u][i] && !c[i] && !(fire && i == m_idx[u]));
    end
    if (!m_valid[u] || fire) begin
      start = (u == 1) ? (m_last[u] + 1) % N : 0;
      found = 1'b0;
      pick  = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (start + k) % N;
        if (!found && m_pend[u][j] && !c[j] && !(m_valid[u] && j == m_idx[u])) begin
          found = 1'b1;
          pick  = j;
        end
      end
      if (fire && u == 1) m_last[u] = m_idx[u];
      m_valid[u] = found;
      m_idx[u]   = pick;
    end
    m_pend[u] = np;
  endtask

  function automatic exp_t model_exp(input int u);
    exp_t e;
    e.valid  = m_valid[u];
    e.idx    = m_idx[u];
    e.onehot = m_valid[u] ? (N'(1) << m_idx[u]) : '0;
    e.pend   = m_pend[u];
    return e;
  endfunction

  // Drives one cycle of stimulus and queues what both DUTs must show after the next edge.
  task automatic step(input logic [N-1:0] s, input logic [N-1:0] c, input logic r);
    @(negedge clk);
    set_in   = s;
    clr_in   = c;
    ready_in = r;
    model_step(0, s, c, r);
    model_step(1, s, c, r);
    q_fx.push_back(model_exp(0));
    q_rr.push_back(model_exp(1));
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) step('0, '0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fx_valid"},  64'(fx_valid),  64'd0);
    check({tag, "_fx_index"},  64'(fx_index),  64'd0);
    check({tag, "_fx_onehot"}, 64'(fx_onehot), 64'd0);
    check({tag, "_fx_pend"},   64'(fx_pend),   64'd0);
    check({tag, "_rr_valid"},  64'(rr_valid),  64'd0);
    check({tag, "_rr_index"},  64'(rr_index),  64'd0);
    check({tag, "_rr_onehot"}, 64'(rr_onehot), 64'd0);
    check({tag, "_rr_pend"},   64'(rr_pend),   64'd0);
  endtask

  // Monitor: pops one expectation per unit after every edge that has one queued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_fx.size() > 0) begin
      e = q_fx.pop_front();
      check("fx_valid",  64'(fx_valid),  64'(e.valid));
      check("fx_index",  64'(fx_index),  64'(e.idx));
      check("fx_onehot", 64'(fx_onehot), 64'(e.onehot));
      check("fx_pend",   64'(fx_pend),   64'(e.pend));
    end
    if (q_rr.size() > 0) begin
      e = q_rr.pop_front();
      check("rr_valid",  64'(rr_valid),  64'(e.valid));
      check("rr_index",  64'(rr_index),  64'(e.idx));
      check("rr_onehot", 64'(rr_onehot), 64'(e.onehot));
      check("rr_pend",   64'(rr_pend),   64'(e.pend));
    end
  end

  initial begin
    reset    = 1'b1;
    set_in   = '0;
    clr_in   = '0;
    ready_in = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Two sparse requests drain lowest-first at one grant per cycle.
    step(4'b1010, '0, 1'b1);
    drain(4);

    // Backpressure holds the offer while a second request arrives.
    step(4'b0001, '0, 1'b1);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step(4'b0100, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    drain(4);

    // Continuous full requests exercise round-robin rotation.
    for (int k = 0; k < 8; k++) step(4'b1111, '0, 1'b1);
    drain(6);

    // Re-request of index 2 in its own accept cycle.
    step(4'b0100, '0, 1'b1);
    step('0, '0, 1'b0);
    step(4'b0100, '0, 1'b1);
    drain(4);

    // Cancel of a pending, non-offered bit.
    step(4'b1001, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, 4'b1000, 1'b0);
    drain(4);

    // Cancel of the offered bit leaves the offer in place until accepted.
    step(4'b0010, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, 4'b0010, 1'b0);
    step('0, '0, 1'b0);
    drain(3);

    // Asynchronous reset while an offer is outstanding.
    step(4'b0110, '0, 1'b0);
    step('0, '0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    q_fx.delete();
    q_rr.delete();
    model_reset();
    set_in   = '0;
    clr_in   = '0;
    ready_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain(4);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] s;
      logic [N-1:0] c;
      logic         r;
      s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      c = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      r = ($urandom_range(0, 3) != 0);
      step(s, c, r);
    end
    drain(8);

    @(posedge clk);
    #2;
    check("queues_drained", 64'(q_fx.size() + q_rr.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_pending_select.md
# vx_pending_select

Sticky request collector and registered selector that sits directly upstream-side of the priority encoding step in arbitration paths. It accumulates single-cycle request pulses from N sources into a pending mask and picks one pending source per handshake, either fixed-priority (lowest index wins) or round-robin. The pick is offered as a registered index/onehot pair on a valid/ready interface. Each bit is retired from the pending mask when its grant is accepted.

## Interface
- N, default 4: number of request sources; legal range is 1 to 64.
- ROUND_ROBIN, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin starting after the last accepted index.
- LN, default LOG2UP(N): index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- set_in  in  N  request pulses; bit i marks source i pending.
- clr_in  in  N  cancel pulses; bit i removes source i from the pending mask.
- valid_out  out  1  a selection is offered.
- ready_in  in  1  consumer accepts the offered selection.
- index_out  out  LN  index of the offered source.
- onehot_out  out  N  one-hot form of index_out.
- pending_out  out  N  registered pending mask.

## Operation
- State:
  - pending[N]
  - out_valid, out_index[LN], out_onehot[N] (output register)
  - last[LN] (round-robin pointer; present only when ROUND_ROBIN=1)
- fire = valid_out & ready_in.
- Pending update: pending_next = (pending & ~clr_mask) | set_in, where clr_mask = clr_in | (fire ? out_onehot : 0).
  - Set wins over any clear of the same bit in the same cycle, so a re-request during its own grant stays pending.
- Candidate mask: cand = pending & ~clr_in & ~(out_valid ? out_onehot : 0).
  - The currently offered bit is never re-picked, including in the fire cycle.
- Output register load condition: (!out_valid || fire).
  - On load: out_valid <= |cand; out_index/out_onehot <= selection from cand.
  - If cand is empty: out_valid <= 0, and out_onehot/out_index <= 0.
- Fixed priority: select the lowest set index of cand.
- Round-robin: select the first set bit of cand scanning (last+1) mod N upward, wrapping.
  - last <= out_index on fire only.
- While valid_out=1 and ready_in=0, index_out and onehot_out are held stable.
  - clr_in of the offered bit does not retract the offer; the bit leaves pending, and the eventual fire has no further effect.
- N=1: index_out is constantly 0 and onehot_out = out_valid; round-robin degenerates to fixed.

## Timing
- Reset values: pending=0, valid_out=0, index_out=0, onehot_out=0, pending_out=0, last=N-1 (so the first round-robin pick favours index 0).
- Reset is asynchronous, so outputs clear immediately on reset assertion, mid-handshake included. Any offered selection is lost.
- Latency: set_in in cycle t gives pending_out in cycle t+1 and valid_out in cycle t+2 when idle.
- Back-to-back throughput is one grant per cycle while cand is non-empty and ready_in=1.
- clr_in in cycle t suppresses picking that bit in cycle t, and the bit is absent from pending_out in t+1 unless it is re-set in t.
- onehot_out is always one-hot when valid_out=1 and all-zero when valid_out=0. index_out is always < N.

## Test plan
- Fixed, N=4, ready_in=1. Stimulus: set_in=4'b1010 for one cycle (cycle 0). Required: pending_out=4'b1010 in cycle 1; cycle 2 index_out=1, onehot_out=4'b0010; cycle 3 index_out=3; cycle 4 valid_out=0, pending_out=0.
- Backpressure, N=4. Stimulus: set_in=4'b0001, then ready_in=0 for 5 cycles, with set_in=4'b0100 arriving meanwhile. Required: index_out holds at 0 the whole time; after ready_in=1, fire grants 0, and the next cycle offers index 2.
- Round-robin, N=4, ready_in=1. Stimulus: set_in=4'b1111 re-pulsed every cycle. Required: grant sequence 0,1,2,3,0,1 with no index repeated before wrap.
- Simultaneous events. Stimulus: offered index 2 fires in the same cycle as set_in[2]=1. Required: pending_out[2]=1 next cycle, and index 2 is granted again later. Stimulus: clr_in[3]=1 while bit 3 is pending but not offered. Required: bit 3 is never offered.
- Cancel of the offered bit. Stimulus: index 1 offered, ready_in=0, clr_in[1]=1. Required: offer stays at index 1, pending_out[1]=0; after fire, valid_out=0 if nothing else is pending.
- Reset mid-operation. Stimulus: assert reset asynchronously while valid_out=1 and pending_out=4'b0110. Required: all outputs are 0 before the next clk edge; after release, valid_out stays 0 until a new set_in.
